stopwatch_time_counter: RTL and testbench
=========================================

// Module: stopwatch_time_counter
// PURPOSE
//  Stopwatch timekeeping stage directly downstream of the centisecond tick divider in watchController.
//  Counts divider ticks into BCD MM:SS.cc and runs the start/stop/lap/clear control FSM.
//  Drives six BCD digits to the display mux/7-seg stage downstream.
//  Lap freezes the display while counting continues.
// PARAMETERS
//  TICKS_PER_CS  1   tick pulses per centisecond increment (internal prescaler; 1 = every tick counts)
//  MIN_MAX       59  last minute value (2 BCD digits, 1..99); MIN_MAX:59.99 wraps to 00:00.00
// PORTS
//  clk        in   1  system clock, all logic on posedge
//  reset      in   1  synchronous, active-low: 0 at a posedge resets the block
//  tick       in   1  1-cycle pulse from the centisecond divider
//  btn_start  in   1  1-cycle debounced pulse: toggle run/stop
//  btn_lap    in   1  1-cycle debounced pulse: toggle lap (display freeze)
//  btn_clear  in   1  1-cycle debounced pulse: zero the count when stopped
//  cs_ones    out  4  displayed centiseconds, ones digit, BCD 0-9
//  cs_tens    out  4  displayed centiseconds, tens digit, BCD 0-9
//  sec_ones   out  4  displayed seconds, ones digit, BCD 0-9
//  sec_tens   out  4  displayed seconds, tens digit, BCD 0-5
//  min_ones   out  4  displayed minutes, ones digit, BCD 0-9
//  min_tens   out  4  displayed minutes, tens digit, BCD 0-9
//  running    out  1  1 in RUN or LAP_RUN
//  lap_active out  1  1 in LAP_RUN or LAP_STOP (display frozen)
//  overflow   out  1  1-cycle pulse on wrap MIN_MAX:59.99 -> 00:00.00
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - state=IDLE; live count, lap latch and prescaler = 0.
//   - All outputs = 0.
//   - Applies mid-operation; overrides every input.
//  States: IDLE, RUN, STOP, LAP_RUN, LAP_STOP. Button priority in one cycle: clear > start > lap; lower-priority buttons ignored.
//   - IDLE:     start -> RUN; lap and clear ignored.
//   - RUN:      start -> STOP; lap -> LAP_RUN, latching the live count; clear ignored.
//   - STOP:     start -> RUN; clear -> IDLE, zeroing count and prescaler; lap ignored.
//   - LAP_RUN:  start -> LAP_STOP; lap -> RUN, display live again; clear ignored.
//   - LAP_STOP: start -> LAP_RUN; lap -> STOP, display live; clear -> IDLE, zeroing count, latch and prescaler.
//  Counting:
//   - A tick is counted only when the registered state is RUN or LAP_RUN.
//   - Tick in the same cycle as start in RUN is counted, then the block stops.
//   - Tick in the same cycle as start from IDLE/STOP is not counted.
//  Prescaler: counts counted ticks 0..TICKS_PER_CS-1; the live count increments on the wrap. Held while stopped.
//  Arithmetic: cascaded BCD digits.
//   - cs_ones 9->0 carries to cs_tens; cs_tens 9->0 carries to sec_ones; sec_ones 9->0 carries to sec_tens.
//   - sec_tens 5->0 carries to minutes.
//   - Minutes form a 2-digit BCD count 0..MIN_MAX; wrap -> 00 and overflow=1 for exactly one cycle.
//   - Counting continues after wrap.
//  Outputs:
//   - Display digits come from the lap latch when lap_active=1, otherwise from the live count.
//   - All outputs are registered; the display reflects a counted tick one cycle after the tick edge.
//   - Lap latch captures the pre-update live count (a same-cycle tick is not included).
//   - running and lap_active follow the registered state.
// STRUCTURE
//  stopwatch_pkg:
//   - state encoding constants (3-bit).
//   - digit maxima CS_MAX_DIGIT=9, SEC_TENS_MAX=5.
//  Sub-module bcd_digit_counter (inputs clk, reset, clr, en, max[3:0]; outputs q[3:0], carry):
//   - 6 instances chained via carry.
//   - Minute wrap at MIN_MAX is decoded in the top level and drives clr of both minute digits.
//  Top level: FSM, prescaler, lap latch, output mux and registers.
// TESTING
//  1. reset=0 for 2 cycles mid-count -> all digits 0, running=0, lap_active=0, state IDLE next cycle.
//  2. start, then 1234 ticks (TICKS_PER_CS=1) -> display 00:12.34, running=1; start again -> later ticks ignored.
//  3. In RUN at 00:05.00: lap, then 300 ticks -> display holds 00:05.00 with lap_active=1; lap again -> display 00:08.00.
//  4. Count forced to 59:59.99 (MIN_MAX=59), one tick -> 00:00.00, overflow high for exactly 1 cycle, running stays 1.
//  5. STOP at 00:00.42, clear+start in the same cycle -> IDLE with all zeros (clear wins); clear while RUN -> ignored.
//  6. TICKS_PER_CS=4: 10 ticks while running -> cs_ones=2; same-cycle start+tick from IDLE -> tick not counted.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared state encoding and digit limits for the stopwatch timekeeping stage.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_STOP     = 3'd2,
        ST_LAP_RUN  = 3'd3,
        ST_LAP_STOP = 3'd4
    } sw_state_e;

    localparam logic [3:0] CS_MAX_DIGIT = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

endpackage

// File: rtl/stopwatch_time_counter_bcd_digit_counter.sv
// One BCD digit: counts 0..max when enabled, carries out on the max->0 step.
module bcd_digit_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic [3:0] max,
    output logic [3:0] q,
    output logic       carry
);

    logic [3:0] q_q, q_d;

    assign carry = en && (q_q == max);
    assign q     = q_q;

    // Next digit value: clear wins over increment.
    always_comb begin
        q_d = q_q;
        if (clr)
            q_d = 4'd0;
        else if (en)
            q_d = (q_q == max) ? 4'd0 : q_q + 4'd1;
    end

    // Digit register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset)
            q_q <= 4'd0;
        else
            q_q <= q_d;
    end

endmodule

// File: rtl/stopwatch_time_counter.sv
// Stopwatch timekeeping: start/stop/lap/clear FSM, centisecond prescaler,
// six cascaded BCD digits (MM:SS.cc), lap freeze latch and registered outputs.
module stopwatch_time_counter
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_CS = 1,
    parameter int MIN_MAX      = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_clear,
    output logic [3:0] cs_ones,
    output logic [3:0] cs_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       lap_active,
    output logic       overflow
);

    localparam int              PS_W     = (TICKS_PER_CS > 1) ? $clog2(TICKS_PER_CS) : 1;
    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(TICKS_PER_CS - 1);
    localparam logic [3:0]      MM_TENS  = 4'(MIN_MAX / 10);
    localparam logic [3:0]      MM_ONES  = 4'(MIN_MAX % 10);
    // Index 0 = cs_ones ... 5 = min_tens.
    localparam logic [5:0][3:0] DIG_MAX  = {CS_MAX_DIGIT, CS_MAX_DIGIT, SEC_TENS_MAX,
                                            CS_MAX_DIGIT, CS_MAX_DIGIT, CS_MAX_DIGIT};

    sw_state_e       state_q, state_d;
    logic [PS_W-1:0] ps_q, ps_d;
    logic [23:0]     lap_q, lap_d, disp_q, disp_d;
    logic            running_q, running_d, lap_act_q, lap_act_d;
    logic            wrap_q, wrap_d, ovf_q, ovf_d;
    logic            clr_cnt, count_en, cs_inc, min_wrap;
    logic [5:0]      dig_en, dig_clr, dig_carry;
    logic [5:0][3:0] live;

    // Control FSM: per-state button priority clear > start > lap; lap entry latches the pre-tick count.
    always_comb begin
        state_d = state_q;
        clr_cnt = 1'b0;
        lap_d   = lap_q;
        case (state_q)
            ST_IDLE:     if (btn_start) state_d = ST_RUN;
            ST_RUN: begin
                if (btn_start)
                    state_d = ST_STOP;
                else if (btn_lap) begin
                    state_d = ST_LAP_RUN;
                    lap_d   = live;
                end
            end
            ST_STOP: begin
                if (btn_clear) begin
                    state_d = ST_IDLE;
                    clr_cnt = 1'b1;
                end else if (btn_start)
                    state_d = ST_RUN;
            end
            ST_LAP_RUN: begin
                if (btn_start)    state_d = ST_LAP_STOP;
                else if (btn_lap) state_d = ST_RUN;
            end
            ST_LAP_STOP: begin
                if (btn_clear) begin
                    state_d = ST_IDLE;
                    clr_cnt = 1'b1;
                    lap_d   = 24'd0;
                end else if (btn_start)
                    state_d = ST_LAP_RUN;
                else if (btn_lap)
                    state_d = ST_STOP;
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    // Prescaler: only ticks seen in a running registered state advance it; its wrap bumps the count.
    always_comb begin
        count_en = tick && (state_q == ST_RUN || state_q == ST_LAP_RUN);
        ps_d     = ps_q;
        cs_inc   = 1'b0;
        if (clr_cnt)
            ps_d = '0;
        else if (count_en) begin
            if (ps_q == PS_LAST) begin
                ps_d   = '0;
                cs_inc = 1'b1;
            end else
                ps_d = ps_q + PS_W'(1);
        end
    end

    // Digit chain enables/clears; minute wrap is decoded here since minutes stop at MIN_MAX, not 99.
    always_comb begin
        dig_en   = {dig_carry[4:0], cs_inc};
        // The tens carry only fires at 99, which coincides with the decode when MIN_MAX is 99.
        min_wrap = (dig_en[4] && live[5] == MM_TENS && live[4] == MM_ONES) || dig_carry[5];
        dig_clr  = {min_wrap, min_wrap, 4'b0000} | {6{clr_cnt}};
    end

    for (genvar i = 0; i < 6; i++) begin : g_dig
        bcd_digit_counter u_dig (
            .clk   (clk),
            .reset (reset),
            .clr   (dig_clr[i]),
            .en    (dig_en[i]),
            .max   (DIG_MAX[i]),
            .q     (live[i]),
            .carry (dig_carry[i])
        );
    end

    // Output stage: display source, status flags and a wrap flag delayed to line up with the zeroed display.
    always_comb begin
        lap_act_d = (state_q == ST_LAP_RUN) || (state_q == ST_LAP_STOP);
        running_d = (state_q == ST_RUN) || (state_q == ST_LAP_RUN);
        disp_d    = lap_act_d ? lap_q : live;
        wrap_d    = min_wrap;
        ovf_d     = wrap_q;
    end

    // State, prescaler, latch and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ps_q      <= '0;
            lap_q     <= 24'd0;
            disp_q    <= 24'd0;
            running_q <= 1'b0;
            lap_act_q <= 1'b0;
            wrap_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ps_q      <= ps_d;
            lap_q     <= lap_d;
            disp_q    <= disp_d;
            running_q <= running_d;
            lap_act_q <= lap_act_d;
            wrap_q    <= wrap_d;
            ovf_q     <= ovf_d;
        end
    end

    assign cs_ones    = disp_q[3:0];
    assign cs_tens    = disp_q[7:4];
    assign sec_ones   = disp_q[11:8];
    assign sec_tens   = disp_q[15:12];
    assign min_ones   = disp_q[19:16];
    assign min_tens   = disp_q[23:20];
    assign running    = running_q;
    assign lap_active = lap_act_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Directed bench: three instances share stimulus (default, MIN_MAX=1 for a
// reachable wrap, TICKS_PER_CS=4 for the prescaler); display read as 24'hMMSScc.
module tb_stopwatch_time_counter;

    logic clk = 1'b0;
    logic reset, tick, btn_start, btn_lap, btn_clear;
    wire [5:0][3:0] dig_a, dig_b, dig_c;
    wire run_a, run_b, run_c, lap_a, lap_b, lap_c, ovf_a, ovf_b, ovf_c;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stopwatch_time_counter u_dut_a (
        .clk(clk), .reset(reset), .tick(tick), .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
        .cs_ones(dig_a[0]), .cs_tens(dig_a[1]), .sec_ones(dig_a[2]), .sec_tens(dig_a[3]),
        .min_ones(dig_a[4]), .min_tens(dig_a[5]), .running(run_a), .lap_active(lap_a), .overflow(ovf_a));

    stopwatch_time_counter #(.MIN_MAX(1)) u_dut_b (
        .clk(clk), .reset(reset), .tick(tick), .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
        .cs_ones(dig_b[0]), .cs_tens(dig_b[1]), .sec_ones(dig_b[2]), .sec_tens(dig_b[3]),
        .min_ones(dig_b[4]), .min_tens(dig_b[5]), .running(run_b), .lap_active(lap_b), .overflow(ovf_b));

    stopwatch_time_counter #(.TICKS_PER_CS(4)) u_dut_c (
        .clk(clk), .reset(reset), .tick(tick), .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
        .cs_ones(dig_c[0]), .cs_tens(dig_c[1]), .sec_ones(dig_c[2]), .sec_tens(dig_c[3]),
        .min_ones(dig_c[4]), .min_tens(dig_c[5]), .running(run_c), .lap_active(lap_c), .overflow(ovf_c));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
        end
    endtask

    task automatic press_start();
        btn_start = 1'b1; step(); btn_start = 1'b0;
    endtask

    task automatic press_lap();
        btn_lap = 1'b1; step(); btn_lap = 1'b0;
    endtask

    task automatic press_clear();
        btn_clear = 1'b1; step(); btn_clear = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0; step(); step(); reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        press_start();
        ticks(7);
        step();
        checks++; if (dig_a !== 24'h000007) begin errors++; $display("FAIL pre_reset_count: got %h want %h", dig_a, 24'h000007); end
        do_reset();
        checks++; if (dig_a !== 24'h000000) begin errors++; $display("FAIL reset_digits: got %h want %h", dig_a, 24'h000000); end
        checks++; if ({run_a, lap_a, ovf_a} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want %b", {run_a, lap_a, ovf_a}, 3'b000); end
        ticks(3);
        step();
        checks++; if (dig_a !== 24'h000000 || run_a !== 1'b0) begin errors++; $display("FAIL reset_idle: got %h/%b want %h/%b", dig_a, run_a, 24'h000000, 1'b0); end
    endtask

    task automatic test_run_stop();
        do_reset();
        press_start();
        ticks(1234);
        step();
        checks++; if (dig_a !== 24'h001234) begin errors++; $display("FAIL run_count: got %h want %h", dig_a, 24'h001234); end
        checks++; if (run_a !== 1'b1) begin errors++; $display("FAIL run_flag: got %b want %b", run_a, 1'b1); end
        press_start();
        ticks(50);
        step();
        checks++; if (dig_a !== 24'h001234 || run_a !== 1'b0) begin errors++; $display("FAIL stop_hold: got %h/%b want %h/%b", dig_a, run_a, 24'h001234, 1'b0); end
        // Tick coinciding with stop while running still counts.
        press_start();
        btn_start = 1'b1; tick = 1'b1; step(); btn_start = 1'b0; tick = 1'b0;
        ticks(5);
        step();
        checks++; if (dig_a !== 24'h001235 || run_a !== 1'b0) begin errors++; $display("FAIL stop_same_tick: got %h/%b want %h/%b", dig_a, run_a, 24'h001235, 1'b0); end
    endtask

    task automatic test_lap();
        do_reset();
        press_start();
        ticks(500);
        press_lap();
        ticks(300);
        step();
        checks++; if (dig_a !== 24'h000500) begin errors++; $display("FAIL lap_freeze: got %h want %h", dig_a, 24'h000500); end
        checks++; if ({lap_a, run_a} !== 2'b11) begin errors++; $display("FAIL lap_flags: got %b want %b", {lap_a, run_a}, 2'b11); end
        press_lap();
        step();
        checks++; if (dig_a !== 24'h000800 || lap_a !== 1'b0) begin errors++; $display("FAIL lap_release: got %h/%b want %h/%b", dig_a, lap_a, 24'h000800, 1'b0); end
        // Latch takes the count before a same-cycle tick.
        btn_lap = 1'b1; tick = 1'b1; step(); btn_lap = 1'b0; tick = 1'b0;
        step();
        checks++; if (dig_a !== 24'h000800) begin errors++; $display("FAIL lap_pre_tick: got %h want %h", dig_a, 24'h000800); end
        press_start();
        ticks(10);
        press_lap();
        step();
        checks++; if (dig_a !== 24'h000801 || {lap_a, run_a} !== 2'b00) begin errors++; $display("FAIL lapstop_to_stop: got %h/%b want %h/%b", dig_a, {lap_a, run_a}, 24'h000801, 2'b00); end
    endtask

    task automatic test_overflow();
        do_reset();
        press_start();
        ticks(11999);
        step();
        checks++; if (dig_b !== 24'h015999 || ovf_b !== 1'b0) begin errors++; $display("FAIL ovf_pre: got %h/%b want %h/%b", dig_b, ovf_b, 24'h015999, 1'b0); end
        tick = 1'b1; step(); tick = 1'b0;
        step();
        checks++; if (dig_b !== 24'h000000 || ovf_b !== 1'b1) begin errors++; $display("FAIL ovf_wrap: got %h/%b want %h/%b", dig_b, ovf_b, 24'h000000, 1'b1); end
        checks++; if (dig_a !== 24'h020000 || ovf_a !== 1'b0) begin errors++; $display("FAIL ovf_no_wrap59: got %h/%b want %h/%b", dig_a, ovf_a, 24'h020000, 1'b0); end
        step();
        checks++; if (ovf_b !== 1'b0 || run_b !== 1'b1) begin errors++; $display("FAIL ovf_pulse_len: got %b/%b want %b/%b", ovf_b, run_b, 1'b0, 1'b1); end
        ticks(3);
        step();
        checks++; if (dig_b !== 24'h000003) begin errors++; $display("FAIL ovf_continue: got %h want %h", dig_b, 24'h000003); end
    endtask

    task automatic test_clear();
        do_reset();
        press_start();
        ticks(42);
        press_start();
        step();
        checks++; if (dig_a !== 24'h000042 || run_a !== 1'b0) begin errors++; $display("FAIL clear_pre: got %h/%b want %h/%b", dig_a, run_a, 24'h000042, 1'b0); end
        btn_clear = 1'b1; btn_start = 1'b1; step(); btn_clear = 1'b0; btn_start = 1'b0;
        step();
        checks++; if (dig_a !== 24'h000000 || run_a !== 1'b0) begin errors++; $display("FAIL clear_wins: got %h/%b want %h/%b", dig_a, run_a, 24'h000000, 1'b0); end
        ticks(3);
        step();
        checks++; if (dig_a !== 24'h000000) begin errors++; $display("FAIL clear_idle: got %h want %h", dig_a, 24'h000000); end
        press_start();
        ticks(5);
        press_clear();
        ticks(2);
        step();
        checks++; if (dig_a !== 24'h000007 || run_a !== 1'b1) begin errors++; $display("FAIL clear_in_run: got %h/%b want %h/%b", dig_a, run_a, 24'h000007, 1'b1); end
        press_lap();
        press_start();
        press_clear();
        step();
        checks++; if (dig_a !== 24'h000000 || {lap_a, run_a} !== 2'b00) begin errors++; $display("FAIL clear_lapstop: got %h/%b want %h/%b", dig_a, {lap_a, run_a}, 24'h000000, 2'b00); end
    endtask

    task automatic test_prescaler();
        do_reset();
        // Tick alongside start from IDLE must be dropped.
        btn_start = 1'b1; tick = 1'b1; step(); btn_start = 1'b0; tick = 1'b0;
        ticks(10);
        step();
        checks++; if (dig_c !== 24'h000002) begin errors++; $display("FAIL ps_ten_ticks: got %h want %h", dig_c, 24'h000002); end
        ticks(2);
        step();
        checks++; if (dig_c !== 24'h000003) begin errors++; $display("FAIL ps_twelve_ticks: got %h want %h", dig_c, 24'h000003); end
        checks++; if (dig_a !== 24'h000012) begin errors++; $display("FAIL start_tick_dropped: got %h want %h", dig_a, 24'h000012); end
    endtask

    initial begin
        reset = 1'b0; tick = 1'b0; btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
        test_reset();
        test_run_stop();
        test_lap();
        test_overflow();
        test_clear();
        test_prescaler();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
